// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and default width for the serial adder
package serial_add_ctrl_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// rtl/serial_add_ctrl_full_adder.sv - single-bit full adder cell
module full_adder (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic Y,
   output logic CO
);

   // Sum and carry of one bit position.
   always_comb begin
      Y  = A ^ B ^ CI;
      CO = (A & B) | (CI & (A ^ B));
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sequencing one full_adder over WIDTH cycles
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             CO
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Only WIDTH-1 result bits need storing; the final bit joins on the exit edge.
   logic [WIDTH-2:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_y;
   logic             fa_co;

   full_adder u_fa (
      .A  (a_sr[0]),
      .B  (b_sr[0]),
      .CI (carry),
      .Y  (fa_y),
      .CO (fa_co)
   );

   assign res_next = {fa_y, res_sr};

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (START) state_next = ST_RUN;
         ST_RUN:  if (cnt == LAST_BIT) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state register only, so nothing leaks from inputs.
   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      case (state)
         ST_RUN:  BUSY = 1'b1;
         ST_DONE: begin
            BUSY = 1'b1;
            DONE = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: operand capture, per-bit shifting and the result/carry-out latch at exit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         SUM    <= '0;
         CO     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  carry <= CI;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               res_sr <= res_next[WIDTH-1:1];
               carry  <= fa_co;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  SUM <= res_next;
                  CO  <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

   logic       CLK;
   logic       RST;
   logic       START;
   logic [7:0] A;
   logic [7:0] B;
   logic       CI;
   logic       BUSY;
   logic       DONE;
   logic [7:0] SUM;
   logic       CO;

   int n_checks;
   int n_fail;
   int cyc;
   int done_cnt;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .CI    (CI),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .SUM   (SUM),
      .CO    (CO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Pulse START for one edge, then wait for DONE; cyc ends as the cycle index of DONE.
   task automatic issue_and_wait(input logic [7:0] a, input logic [7:0] b, input logic ci);
      A = a;
      B = b;
      CI = ci;
      START = 1'b1;
      tick();
      START = 1'b0;
      cyc = 1;
      while (!DONE && cyc < 30) begin
         tick();
         cyc++;
      end
   endtask

   task automatic add_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic [7:0] esum, input logic eco);
      issue_and_wait(a, b, ci);
      chk({tag, "_latency"}, cyc, 9);
      chk({tag, "_done"}, DONE, 1'b1);
      chk({tag, "_busy_in_done"}, BUSY, 1'b1);
      chk({tag, "_sum"}, SUM, esum);
      chk({tag, "_co"}, CO, eco);
      tick();
      chk({tag, "_idle_busy"}, BUSY, 1'b0);
      chk({tag, "_idle_done"}, DONE, 1'b0);
      chk({tag, "_sum_held"}, SUM, esum);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      RST   = 1'b1;
      START = 1'b0;
      A     = 8'h00;
      B     = 8'h00;
      CI    = 1'b0;
      tick();
      tick();
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_sum", SUM, 8'h00);
      chk("rst_co", CO, 1'b0);
      RST = 1'b0;
      tick();

      add_case("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      add_case("ff_p1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      add_case("a5_5a_ci", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

      // Operands change mid-RUN; the captured values must win, and SUM holds meanwhile.
      A = 8'h3C;
      B = 8'h42;
      CI = 1'b0;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      A = 8'hFF;
      B = 8'hFF;
      CI = 1'b1;
      chk("mid_busy", BUSY, 1'b1);
      chk("mid_sum_held", SUM, 8'h00);
      chk("mid_co_held", CO, 1'b1);
      cyc = 3;
      while (!DONE && cyc < 30) begin
         tick();
         cyc++;
      end
      chk("mid_latency", cyc, 9);
      chk("mid_sum", SUM, 8'h7E);
      chk("mid_co", CO, 1'b0);
      tick();

      // START held high: second add accepted only at the end of cycle 10.
      A = 8'h10;
      B = 8'h20;
      CI = 1'b0;
      START = 1'b1;
      tick();
      done_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         if (DONE) done_cnt++;
         if (c == 9) begin
            chk("held_done1", DONE, 1'b1);
            chk("held_sum1", SUM, 8'h30);
         end
         if (c == 10) chk("held_idle_busy", BUSY, 1'b0);
         if (c == 11) chk("held_second_busy", BUSY, 1'b1);
         if (c == 19) begin
            chk("held_done2", DONE, 1'b1);
            chk("held_sum2", SUM, 8'h30);
         end
         if (c < 20) tick();
      end
      chk("held_done_count", done_cnt, 2);
      START = 1'b0;
      tick();
      tick();

      // Reset asserted in cycle 4 of a run discards it immediately.
      A = 8'h77;
      B = 8'h11;
      CI = 1'b1;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_rst_busy", BUSY, 1'b1);
      chk("pre_rst_sum", SUM, 8'h30);
      RST = 1'b1;
      #1;
      chk("mrst_busy", BUSY, 1'b0);
      chk("mrst_done", DONE, 1'b0);
      chk("mrst_sum", SUM, 8'h00);
      chk("mrst_co", CO, 1'b0);
      tick();
      RST = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (DONE) done_cnt++;
      end
      chk("mrst_no_done", done_cnt, 0);
      chk("mrst_sum_stays", SUM, 8'h00);

      add_case("one_p1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
